wb_collector: RTL and testbench
===============================

Name: wb_collector

Overview:
- Transmitter side of the scoreboard write-back interface.
- Collects results from NR_SOURCES functional units, buffers each in a small per-source FIFO, and drives the scoreboard write-back ports (trans_id/wbdata/ex/wb_valid).
- Allocates ports round-robin, up to NR_WB_PORTS results per cycle.
- Gives FUs a ready/valid handshake; the scoreboard side has no backpressure.

Parameters:
- NR_SOURCES, 4, number of functional-unit result producers
- NR_WB_PORTS, 2, scoreboard write-back ports driven (1..NR_SOURCES)
- FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- flush_i  in  1  drop all buffered results
- src_valid_i  in  NR_SOURCES  source k offers a result
- src_ready_o  out  NR_SOURCES  source k FIFO can accept
- src_trans_id_i  in  NR_SOURCES x TRANS_ID_BITS  scoreboard transaction ID per source
- src_data_i  in  NR_SOURCES x 64  result data per source
- src_ex_i  in  NR_SOURCES x exception_t  exception per source
- trans_id_o  out  NR_WB_PORTS x TRANS_ID_BITS  to scoreboard trans_id_i
- wbdata_o  out  NR_WB_PORTS x 64  to scoreboard wbdata_i
- ex_o  out  NR_WB_PORTS x exception_t  to scoreboard ex_i
- wb_valid_o  out  NR_WB_PORTS  to scoreboard wb_valid_i

Behaviour:
- Reset (rst_i high, async):
  - all FIFOs empty, rr_q=0
  - wb_valid_o=0; trans_id_o, wbdata_o, ex_o = 0
  - src_ready_o all 1 once rst_i deasserts (0 while asserted)
- Push:
  - src_valid_i[k] && src_ready_o[k] writes {trans_id, data, ex} into FIFO k at the clock edge.
  - src_ready_o[k] = (count_q[k] != FIFO_DEPTH), from registered count only.
  - No combinational path from the scoreboard side or from pop.
- Latency: a pushed result is visible on a port no earlier than the following cycle. There is no bypass.
- Arbitration (combinational, from registered state):
  - Scan sources in order rr_q, rr_q+1, ... modulo NR_SOURCES.
  - The first NR_WB_PORTS non-empty FIFOs are granted; the j-th grant drives port j.
  - Unused ports: wb_valid_o=0 and data fields driven 0.
- Pop: every granted FIFO pops its head at the edge. Output is always consumed; no ready from the scoreboard.
- Pointer update: if there is any grant, rr_q <= (index of last granted source + 1) mod NR_SOURCES; otherwise rr_q holds.
- Simultaneous push and pop on the same FIFO: count unchanged; the FIFO remains ordered.
- Full FIFO: src_ready_o=0. A source holding valid is not lost; it retries.
- Wrap-around: FIFO read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. rr_q wraps modulo NR_SOURCES (non-power-of-two is handled explicitly).
- Ordering: results from one source leave in push order. No ordering guarantee exists across sources.
- Flush:
  - While flush_i=1, wb_valid_o is forced to 0 and pushes are discarded.
  - All FIFOs clear at the edge; rr_q is reset to 0.
  - src_ready_o in that cycle still follows count_q.
- Reset mid-operation: all state is cleared immediately (async); buffered results are lost.
- ex_o and data pass through unmodified. The collector never alters ex.valid.

Optional Feature:
- Macro: WB_COLLECTOR_EX_FIRST_EN.
- Defined: arbitration takes two passes.
  - Pass 1 grants round-robin among non-empty FIFOs whose head has ex.valid=1.
  - Pass 2 fills remaining ports round-robin with the other non-empty FIFOs.
  - rr_q advances past the last granted source of the final grant order.
  - Exceptions reach the scoreboard earliest.
- Not defined: single-pass round-robin as above, with no head inspection.

Decomposition:
- ariane_pkg provides:
  - TRANS_ID_BITS and exception_t (existing)
  - new wb_entry_t packed struct {trans_id, data[63:0], ex}
  - WB_COLLECTOR_MAX_SOURCES constant (8) used for the parameter check
- Sub-module wb_src_fifo:
  - one per source, parameterised by FIFO_DEPTH
  - ports push/pop/flush, head, count, full/empty
  - instantiated in a generate loop
- Arbitration and the port mux stay in wb_collector.

Test Plan:
- Reset then single push: source 2 pushes {id=5, data=0xDEAD} at cycle 0 -> cycle 1: port0 valid, trans_id 5, wbdata 0xDEAD; port1 invalid; cycle 2: all invalid.
- Contention (4 sources, 2 ports, rr_q=0): all 4 push in one cycle, ids 0-3.
  - Cycle 1: ports carry ids 0,1; rr_q becomes 2.
  - Cycle 2: ports carry ids 2,3.
- Backpressure: source 0 pushes ids 1,2,3,4 on consecutive cycles.
  - With FIFO_DEPTH=2 and one port shared with source 1 held busy, src_ready_o[0]=0 when the count hits 2.
  - Ids 1-4 still appear in order, with no drops and no duplicates.
- Flush: 3 results buffered, flush_i=1 for one cycle -> wb_valid_o=0 that cycle, all counts 0 next cycle, a push attempted in the flush cycle never appears, rr_q=0.
- Async reset mid-stream: rst_i asserted between edges with buffered data -> wb_valid_o drops to 0 immediately, with no emission after reset release.
- WB_COLLECTOR_EX_FIRST_EN: sources 0,1,3 non-empty, only source 3 head has ex.valid=1, rr_q=0 -> port0 = source 3, port1 = source 0. With the macro undefined -> port0 = source 0, port1 = source 1.

Source files
------------

// File: rtl/ariane_pkg.sv
// ============================================================================
// ariane_pkg : shared scoreboard types and the write-back collector entry type
// Revision   : 1.0
// ============================================================================
`default_nettype none

package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS            = 3;
  localparam int unsigned WB_COLLECTOR_MAX_SOURCES = 8;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              data;
    exception_t               ex;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_collector_src_fifo.sv
// ============================================================================
// wb_src_fifo : per-source result FIFO (power-of-two depth, flushable)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_src_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              din,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  // Depth is a power of two, so the count MSB alone marks "full".
  assign full    = count_q[PTR_W];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/wb_collector.sv
// ============================================================================
// wb_collector : buffers FU results and drives scoreboard write-back ports
//                round-robin; WB_COLLECTOR_EX_FIRST_EN grants exceptions first
// Revision     : 1.0
// ============================================================================
`default_nettype none

module wb_collector
  import ariane_pkg::*;
#(
  parameter int unsigned NR_SOURCES  = 4,
  parameter int unsigned NR_WB_PORTS = 2,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       flush_i,
  input  logic       [NR_SOURCES-1:0]                src_valid_i,
  output logic       [NR_SOURCES-1:0]                src_ready_o,
  input  logic       [NR_SOURCES-1:0][TRANS_ID_BITS-1:0] src_trans_id_i,
  input  logic       [NR_SOURCES-1:0][63:0]          src_data_i,
  input  exception_t [NR_SOURCES-1:0]                src_ex_i,
  output logic       [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_o,
  output logic       [NR_WB_PORTS-1:0][63:0]         wbdata_o,
  output exception_t [NR_WB_PORTS-1:0]               ex_o,
  output logic       [NR_WB_PORTS-1:0]               wb_valid_o
);

  localparam int unsigned IDX_W = (NR_SOURCES > 1) ? $clog2(NR_SOURCES) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef WB_COLLECTOR_EX_FIRST_EN
  localparam int NR_PASSES = 2;
`else
  localparam int NR_PASSES = 1;
`endif

  if ((NR_SOURCES < 1) || (NR_SOURCES > WB_COLLECTOR_MAX_SOURCES) ||
      (NR_WB_PORTS < 1) || (NR_WB_PORTS > NR_SOURCES) ||
      (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_cfg
    $error("wb_collector: invalid parameter combination");
  end

  wb_entry_t [NR_SOURCES-1:0]             push_entry;
  wb_entry_t [NR_SOURCES-1:0]             head;
  logic      [NR_SOURCES-1:0]             push;
  logic      [NR_SOURCES-1:0]             pop;
  logic      [NR_SOURCES-1:0]             full;
  logic      [NR_SOURCES-1:0]             empty;
  logic      [NR_SOURCES-1:0][CNT_W-1:0]  count_q;
  logic      [IDX_W-1:0]                  rr_q;
  logic      [IDX_W-1:0]                  rr_d;
  logic      [IDX_W-1:0]                  idx;
  logic                                   elig;
  logic      [NR_WB_PORTS-1:0]            grant_vld;
  logic      [NR_WB_PORTS-1:0][IDX_W-1:0] grant_src;

  // Operand is always below 2*NR_SOURCES, so one conditional subtract wraps it.
  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    int unsigned w;
    w = (v >= NR_SOURCES) ? v - NR_SOURCES : v;
    return w[IDX_W-1:0];
  endfunction

  for (genvar k = 0; k < NR_SOURCES; k++) begin : g_src
    assign push_entry[k]  = '{trans_id: src_trans_id_i[k], data: src_data_i[k], ex: src_ex_i[k]};
    assign src_ready_o[k] = ~rst_i & (count_q[k] != CNT_W'(FIFO_DEPTH));
    assign push[k]        = src_valid_i[k] & ~full[k] & ~rst_i & ~flush_i;

    wb_src_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) i_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .flush (flush_i),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (push_entry[k]),
      .head  (head[k]),
      .count (count_q[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  // Each port restarts the scan at rr_q and skips sources already granted,
  // so port j receives the j-th eligible source in round-robin order.
  always_comb begin
    idx       = '0;
    elig      = 1'b0;
    pop       = '0;
    grant_vld = '0;
    grant_src = '0;
    for (int j = 0; j < NR_WB_PORTS; j++) begin
      for (int p = 0; p < NR_PASSES; p++) begin
        for (int i = 0; i < NR_SOURCES; i++) begin
          idx = wrap_idx(32'(rr_q) + 32'(i));
`ifdef WB_COLLECTOR_EX_FIRST_EN
          elig = ~empty[idx] & (head[idx].ex.valid == (p == 0));
`else
          elig = ~empty[idx];
`endif
          if (!grant_vld[j] && elig && !pop[idx]) begin
            grant_vld[j] = 1'b1;
            grant_src[j] = idx;
            pop[idx]     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    for (int j = 0; j < NR_WB_PORTS; j++) begin
      if (grant_vld[j]) rr_d = wrap_idx(32'(grant_src[j]) + 32'd1);
    end
  end

  always_comb begin
    wb_valid_o = '0;
    trans_id_o = '0;
    wbdata_o   = '0;
    ex_o       = '0;
    for (int j = 0; j < NR_WB_PORTS; j++) begin
      if (grant_vld[j] && !flush_i) begin
        wb_valid_o[j] = 1'b1;
        trans_id_o[j] = head[grant_src[j]].trans_id;
        wbdata_o[j]   = head[grant_src[j]].data;
        ex_o[j]       = head[grant_src[j]].ex;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (flush_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_collector.sv
// ============================================================================
// tb_wb_collector : directed self-checking bench for wb_collector
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_wb_collector;
  import ariane_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned NP = 2;
  localparam int unsigned FD = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic       [NS-1:0]                    src_valid;
  logic       [NS-1:0]                    src_ready;
  logic       [NS-1:0][TRANS_ID_BITS-1:0] src_trans_id;
  logic       [NS-1:0][63:0]              src_data;
  exception_t [NS-1:0]                    src_ex;
  logic       [NP-1:0][TRANS_ID_BITS-1:0] trans_id;
  logic       [NP-1:0][63:0]              wbdata;
  exception_t [NP-1:0]                    ex;
  logic       [NP-1:0]                    wb_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_collector #(
    .NR_SOURCES  (NS),
    .NR_WB_PORTS (NP),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .src_valid_i    (src_valid),
    .src_ready_o    (src_ready),
    .src_trans_id_i (src_trans_id),
    .src_data_i     (src_data),
    .src_ex_i       (src_ex),
    .trans_id_o     (trans_id),
    .wbdata_o       (wbdata),
    .ex_o           (ex),
    .wb_valid_o     (wb_valid)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    src_valid    = '0;
    src_trans_id = '0;
    src_data     = '0;
    src_ex       = '0;
    flush        = 1'b0;
  endtask

  task automatic set_src(input int k, input int id, input logic [63:0] d, input logic exv);
    src_valid[k]       = 1'b1;
    src_trans_id[k]    = TRANS_ID_BITS'(id);
    src_data[k]        = d;
    src_ex[k]          = '0;
    src_ex[k].valid    = exv;
    src_ex[k].cause    = exv ? 64'd2 : 64'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  exp_id;
    bit  saw_full;
    int  sent;
    logic accepted;

    // ---------------- reset state ----------------
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #2;
    check_eq("rst_valid", 64'(wb_valid), 64'd0);
    check_eq("rst_ready", 64'(src_ready), 64'd0);
    check_eq("rst_tid0", 64'(trans_id[0]), 64'd0);
    check_eq("rst_data1", wbdata[1], 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 64'(src_ready), 64'hF);

    // ---------------- single push, source 2 ----------------
    set_src(2, 5, 64'hDEAD, 1'b0);
    check_eq("no_bypass", 64'(wb_valid), 64'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_eq("single_valid", 64'(wb_valid), 64'b01);
    check_eq("single_tid0", 64'(trans_id[0]), 64'd5);
    check_eq("single_data0", wbdata[0], 64'hDEAD);
    check_eq("single_tid1", 64'(trans_id[1]), 64'd0);
    check_eq("single_data1", wbdata[1], 64'd0);
    @(negedge clk);
    check_eq("single_drained", 64'(wb_valid), 64'd0);

    // ---------------- contention, rr_q = 0 ----------------
    do_reset();
    for (int k = 0; k < 4; k++) set_src(k, k, 64'h100 + 64'(k), 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_eq("cont_c1_valid", 64'(wb_valid), 64'b11);
    check_eq("cont_c1_tid0", 64'(trans_id[0]), 64'd0);
    check_eq("cont_c1_tid1", 64'(trans_id[1]), 64'd1);
    check_eq("cont_c1_data1", wbdata[1], 64'h101);
    @(negedge clk);
    check_eq("cont_c2_valid", 64'(wb_valid), 64'b11);
    check_eq("cont_c2_tid0", 64'(trans_id[0]), 64'd2);
    check_eq("cont_c2_tid1", 64'(trans_id[1]), 64'd3);
    check_eq("cont_c2_data0", wbdata[0], 64'h102);
    @(negedge clk);
    check_eq("cont_c3_valid", 64'(wb_valid), 64'd0);

    // ---------------- backpressure on source 0 ----------------
    next_cycle();
    exp_id   = 1;
    saw_full = 1'b0;
    sent     = 0;
    for (int cyc = 0; cyc < 60 && exp_id <= 4; cyc++) begin
      for (int k = 1; k < 4; k++) set_src(k, 4 + k, 64'h200 + 64'(k), 1'b0);
      if (sent < 4) set_src(0, sent + 1, 64'hA0 + 64'(sent + 1), 1'b0);
      else src_valid[0] = 1'b0;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p] && trans_id[p] >= 3'd1 && trans_id[p] <= 3'd4) begin
          check_eq("bp_order", 64'(trans_id[p]), 64'(exp_id));
          check_eq("bp_data", wbdata[p], 64'hA0 + 64'(exp_id));
          exp_id++;
        end
      end
      if (!src_ready[0]) saw_full = 1'b1;
      accepted = src_valid[0] & src_ready[0];
      next_cycle();
      if (accepted) sent++;
    end
    check_eq("bp_all_received", 64'(exp_id), 64'd5);
    check_eq("bp_saw_full", 64'(saw_full), 64'd1);
    idle_inputs();
    repeat (6) next_cycle();
    @(negedge clk);
    check_eq("bp_drained", 64'(wb_valid), 64'd0);

    // ---------------- flush (rr_q first moved to 2) ----------------
    set_src(1, 1, 64'h11, 1'b0);
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();
    set_src(0, 1, 64'h51, 1'b0);
    set_src(1, 2, 64'h52, 1'b0);
    set_src(2, 3, 64'h53, 1'b0);
    next_cycle();
    idle_inputs();
    flush = 1'b1;
    set_src(3, 4, 64'h54, 1'b0);
    @(negedge clk);
    check_eq("flush_valid", 64'(wb_valid), 64'd0);
    check_eq("flush_ready", 64'(src_ready), 64'hF);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_eq("post_flush_valid", 64'(wb_valid), 64'd0);

    // ---------------- rr_q=0 after flush; exception-first ordering ----------------
    set_src(0, 1, 64'hB0, 1'b0);
    set_src(1, 2, 64'hB1, 1'b0);
    set_src(3, 3, 64'hB3, 1'b1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_eq("arb_valid", 64'(wb_valid), 64'b11);
`ifdef WB_COLLECTOR_EX_FIRST_EN
    check_eq("arb_tid0", 64'(trans_id[0]), 64'd3);
    check_eq("arb_ex0", 64'(ex[0].valid), 64'd1);
    check_eq("arb_tid1", 64'(trans_id[1]), 64'd1);
    @(negedge clk);
    check_eq("arb_c2_valid", 64'(wb_valid), 64'b01);
    check_eq("arb_c2_tid0", 64'(trans_id[0]), 64'd2);
`else
    check_eq("arb_tid0", 64'(trans_id[0]), 64'd1);
    check_eq("arb_tid1", 64'(trans_id[1]), 64'd2);
    check_eq("arb_data1", wbdata[1], 64'hB1);
    @(negedge clk);
    check_eq("arb_c2_valid", 64'(wb_valid), 64'b01);
    check_eq("arb_c2_tid0", 64'(trans_id[0]), 64'd3);
    check_eq("arb_c2_ex0", 64'(ex[0].valid), 64'd1);
    check_eq("arb_c2_cause0", ex[0].cause, 64'd2);
`endif

    // ---------------- async reset mid-stream ----------------
    next_cycle();
    for (int k = 0; k < 4; k++) set_src(k, k + 1, 64'h300 + 64'(k), 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_eq("pre_rst_valid", 64'(wb_valid), 64'b11);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(wb_valid), 64'd0);
    check_eq("async_rst_ready", 64'(src_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("post_rst_no_emit", 64'(wb_valid), 64'd0);
    end
    check_eq("post_rst_ready", 64'(src_ready), 64'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
